// File: rtl/adc_pkg.sv
// Shared definitions for the dual serial-ADC front end.
//   state_t     : sequencer states (IDLE, CONV, QUIET, ACC)
//   ADC_W       : conversion result width per channel
//   FRAME_BITS  : SCLK cycles per conversion frame
//   LEAD_BITS   : leading frame bits that carry no data
//   acc_width() : accumulator width that cannot overflow for 2^avg_log2 samples
package adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    QUIET = 2'd2,
    ACC   = 2'd3
  } state_t;

  localparam int ADC_W      = 12;
  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = FRAME_BITS - ADC_W;

  function automatic int acc_width(input int adc_w, input int avg_log2);
    return adc_w + avg_log2;
  endfunction

endpackage

// File: rtl/adc_chan_acc.sv
// One ADC channel: input synchroniser, serial shift register, window
// accumulator and averaged output register.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   sdata        : raw serial data from the ADC, MSB first
//   sample_en    : shift the synchronised bit in (SCLK rising edge)
//   acc_en       : add the captured word to the accumulator (ACC state)
//   last_frame   : this ACC closes the averaging window
//   clear        : discard the window (has priority over acc_en)
//   avg_out      : averaged result, updated when the window closes
module adc_chan_acc #(
  parameter int ADC_W    = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdata,
  input  logic             sample_en,
  input  logic             acc_en,
  input  logic             last_frame,
  input  logic             clear,
  output logic [ADC_W-1:0] avg_out
);
  import adc_pkg::*;

  localparam int ACC_W = acc_width(ADC_W, AVG_LOG2);

  logic             sdata_p0;
  logic             sdata_p1;
  logic [ADC_W-1:0] shreg;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;

  // Truncating divide by the window length.
  function automatic logic [ADC_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return ADC_W'(sum >> AVG_LOG2);
  endfunction

  assign acc_sum = acc + ACC_W'(shreg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sdata_p0 <= 1'b0;
      sdata_p1 <= 1'b0;
      shreg    <= '0;
      acc      <= '0;
      avg_out  <= '0;
    end else begin
      // stage p0/p1: two-flop synchroniser
      sdata_p0 <= sdata;
      sdata_p1 <= sdata_p0;
      // shift stage: only the last ADC_W bits survive, so leading bits fall off
      if (sample_en) begin
        shreg <= {shreg[ADC_W-2:0], sdata_p1};
      end
      // accumulate stage
      if (clear) begin
        acc <= '0;
      end else if (acc_en) begin
        if (last_frame) begin
          avg_out <= avg_trunc(acc_sum);
          acc     <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: rtl/adc_dual_sampler.sv
// Front end for the PSO MPPT controller: drives two serial ADCs sharing
// CS/SCLK, averages 2^AVG_LOG2 conversions per channel and presents the
// averages with a one-cycle strobe.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   ena               : level-sensitive sampling enable
//   sdata1, sdata2    : serial data from ADC1 (voltage) / ADC2 (current)
//   adc_cs_n          : shared chip select, active low
//   adc_sclk          : shared serial clock, idles high
//   ad1_out, ad2_out  : averaged results
//   sample_valid      : one-cycle pulse, outputs updated on the same edge
// CLK_DIV is the SCLK half-period in clk cycles and must be >= 2 so the
// synchroniser settles before the rising-edge sample.
module adc_dual_sampler #(
  parameter int CLK_DIV    = 4,
  parameter int AVG_LOG2   = 3,
  parameter int ADC_W      = adc_pkg::ADC_W,
  parameter int FRAME_BITS = adc_pkg::FRAME_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ena,
  input  logic             sdata1,
  input  logic             sdata2,
  output logic             adc_cs_n,
  output logic             adc_sclk,
  output logic [ADC_W-1:0] ad1_out,
  output logic [ADC_W-1:0] ad2_out,
  output logic             sample_valid
);
  import adc_pkg::*;

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam int FC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HIGH = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'((1 << AVG_LOG2) - 1);

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [FC_W-1:0]   frame_cnt;
  logic              drop_seen;
  logic              sample_en;
  logic              acc_en;
  logic              last_frame;
  logic              discard;
  logic              clear_acc;
  logic              cs_n_nxt;
  logic              sclk_nxt;

  assign last_frame = (frame_cnt == FC_LAST);
  // Any ena drop during the frame, or at the ACC cycle itself, voids the window.
  assign discard    = drop_seen | ~ena;
  assign clear_acc  = acc_en & discard;

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    sample_en = 1'b0;
    acc_en    = 1'b0;
    case (state)
      IDLE: begin
        if (ena) begin
          state_nxt = CONV;
          div_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      CONV: begin
        // SCLK rises on the edge leaving the last low cycle of the bit.
        sample_en = (div_cnt == DIV_RISE);
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (bit_cnt == BIT_LAST) begin
            state_nxt = QUIET;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_cnt + 1'b1;
          end
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      QUIET: begin
        if (div_cnt == DIV_LAST) begin
          state_nxt = ACC;
          div_nxt   = '0;
        end else begin
          div_nxt = div_cnt + 1'b1;
        end
      end
      ACC: begin
        acc_en    = 1'b1;
        state_nxt = ena ? CONV : IDLE;
        div_nxt   = '0;
        bit_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Pin outputs are registered from the next-state view so they line up
    // with the state they describe.
    cs_n_nxt = (state_nxt != CONV);
    sclk_nxt = (state_nxt == CONV) ? (div_nxt >= DIV_HIGH) : 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      frame_cnt    <= '0;
      drop_seen    <= 1'b0;
      adc_cs_n     <= 1'b1;
      adc_sclk     <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      div_cnt      <= div_nxt;
      bit_cnt      <= bit_nxt;
      adc_cs_n     <= cs_n_nxt;
      adc_sclk     <= sclk_nxt;
      sample_valid <= acc_en & last_frame & ~discard;
      if (acc_en) begin
        drop_seen <= 1'b0;
        frame_cnt <= (discard | last_frame) ? '0 : frame_cnt + 1'b1;
      end else if ((state != IDLE) && !ena) begin
        drop_seen <= 1'b1;
      end
    end
  end

  adc_chan_acc #(
    .ADC_W    (ADC_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_chan1 (
    .clk        (clk),
    .reset      (reset),
    .sdata      (sdata1),
    .sample_en  (sample_en),
    .acc_en     (acc_en),
    .last_frame (last_frame),
    .clear      (clear_acc),
    .avg_out    (ad1_out)
  );

  adc_chan_acc #(
    .ADC_W    (ADC_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_chan2 (
    .clk        (clk),
    .reset      (reset),
    .sdata      (sdata2),
    .sample_en  (sample_en),
    .acc_en     (acc_en),
    .last_frame (last_frame),
    .clear      (clear_acc),
    .avg_out    (ad2_out)
  );

endmodule

// File: tb/tb_adc_dual_sampler.sv
// Bench for adc_dual_sampler at default parameters: behavioural ADC pair,
// table of averaging windows feeding a scoreboard, plus hand-written
// sequences for timing, ena drop and mid-frame reset.
module tb_adc_dual_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ena = 1'b0;
  logic        sdata1 = 1'b0;
  logic        sdata2 = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] ad1_out;
  logic [11:0] ad2_out;
  logic        sample_valid;

  always #5 clk = ~clk;

  adc_dual_sampler dut (
    .clk          (clk),
    .reset        (reset),
    .ena          (ena),
    .sdata1       (sdata1),
    .sdata2       (sdata2),
    .adc_cs_n     (adc_cs_n),
    .adc_sclk     (adc_sclk),
    .ad1_out      (ad1_out),
    .ad2_out      (ad2_out),
    .sample_valid (sample_valid)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // ADC model: latches a frame word on CS fall, drives the next bit just
  // after each SCLK fall. Leading bits are 4'b1010.
  logic [11:0] q1[$];
  logic [11:0] q2[$];
  logic [11:0] def1 = 12'h555;
  logic [11:0] def2 = 12'h2AA;
  logic [15:0] word1 = '0;
  logic [15:0] word2 = '0;
  int          bit_idx = 0;

  always @(negedge adc_cs_n) begin
    if (q1.size() > 0) word1 = {4'b1010, q1.pop_front()};
    else               word1 = {4'b1010, def1};
    if (q2.size() > 0) word2 = {4'b1010, q2.pop_front()};
    else               word2 = {4'b1010, def2};
    bit_idx = 0;
  end

  always @(negedge adc_sclk) begin
    #1;
    if (!adc_cs_n && bit_idx < 16) begin
      sdata1 = word1[15-bit_idx];
      sdata2 = word2[15-bit_idx];
      bit_idx++;
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [11:0] e1;
    logic [11:0] e2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_valid = 0;

  always @(negedge clk) begin
    if (reset && sample_valid) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=pulse required=none ad1=%0d ad2=%0d", ad1_out, ad2_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("avg_ad1", 32'(ad1_out), 32'(mon_e.e1));
        check("avg_ad2", 32'(ad2_out), 32'(mon_e.e2));
      end
    end
  end

  typedef struct packed {
    logic [7:0][11:0] s1;
    logic [7:0][11:0] s2;
    logic [11:0]      e1;
    logic [11:0]      e2;
  } vec_t;

  vec_t vecs[5];

  task automatic push_window(input logic [7:0][11:0] s1, input logic [7:0][11:0] s2,
                             input logic [11:0] e1, input logic [11:0] e2);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      q1.push_back(s1[j]);
      q2.push_back(s2[j]);
    end
    e.e1 = e1;
    e.e2 = e2;
    exp_q.push_back(e);
  endtask

  task automatic wait_cs_fall(input string name);
    int n;
    n = 0;
    while (adc_cs_n == 1'b0 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    while (adc_cs_n == 1'b1 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) timeout_fail(name);
  endtask

  task automatic wait_valids(input int target, input int limit, input string name);
    int n;
    n = 0;
    while (n_valid < target && n < limit) begin
      @(posedge clk); #1; n++;
    end
    if (n_valid < target) timeout_fail(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lowcnt, hicnt, tot, rises, n, lowseen;
    logic prev_sclk;
    logic [7:0][11:0] s1, s2;

    // Window table: samples per frame and hand-computed truncated averages.
    for (int j = 0; j < 8; j++) begin
      vecs[0].s1[j] = 12'hABC;
      vecs[0].s2[j] = 12'h123;
      vecs[1].s1[j] = 12'(j);
      vecs[1].s2[j] = (j % 2 == 0) ? 12'd4095 : 12'd4094;
      vecs[2].s1[j] = 12'hFFF;
      vecs[2].s2[j] = 12'hFFF;
      vecs[3].s1[j] = 12'h000;
      vecs[3].s2[j] = 12'h000;
      vecs[4].s1[j] = 12'(100 * (j + 1));
      vecs[4].s2[j] = (j == 7) ? 12'd0 : 12'd1;
    end
    vecs[0].e1 = 12'hABC; vecs[0].e2 = 12'h123;
    vecs[1].e1 = 12'd3;   vecs[1].e2 = 12'd4094;
    vecs[2].e1 = 12'hFFF; vecs[2].e2 = 12'hFFF;
    vecs[3].e1 = 12'd0;   vecs[3].e2 = 12'd0;
    vecs[4].e1 = 12'd450; vecs[4].e2 = 12'd0;

    // Reset held with ena high
    reset = 1'b0;
    ena   = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_cs_n", 32'(adc_cs_n), 32'd1);
    check("reset_sclk", 32'(adc_sclk), 32'd1);
    check("reset_ad1", 32'(ad1_out), 32'd0);
    check("reset_ad2", 32'(ad2_out), 32'd0);
    check("reset_valid", 32'(sample_valid), 32'd0);

    for (int v = 0; v < 5; v++) push_window(vecs[v].s1, vecs[v].s2, vecs[v].e1, vecs[v].e2);

    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("first_cs_fall", 32'(adc_cs_n), 32'd0);

    // Frame timing on the first frame
    lowcnt = 0;
    rises = 0;
    prev_sclk = adc_sclk;
    while (!adc_cs_n && lowcnt < 1000) begin
      lowcnt++;
      @(posedge clk); #1;
      if (!adc_cs_n && !prev_sclk && adc_sclk) rises++;
      prev_sclk = adc_sclk;
    end
    check("cs_low_cycles", 32'(lowcnt), 32'd128);
    check("sclk_rises", 32'(rises), 32'd16);
    check("sclk_idle_high", 32'(adc_sclk), 32'd1);
    hicnt = 0;
    while (adc_cs_n && hicnt < 1000) begin
      hicnt++;
      @(posedge clk); #1;
    end
    check("frame_period", 32'(lowcnt + hicnt), 32'd137);
    tot = lowcnt + hicnt;
    while (!sample_valid && tot < 3000) begin
      tot++;
      @(posedge clk); #1;
    end
    check("first_valid_latency", 32'(tot), 32'd1096);

    wait_valids(5, 6000, "table_windows");

    // ena drop during frame 3 of the next window
    for (int k = 0; k < 3; k++) wait_cs_fall("drop_frame_start");
    repeat (20) @(posedge clk);
    #1;
    ena = 1'b0;
    n = 0;
    while (!adc_cs_n && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("drop_frame_len", 32'(20 + n), 32'd128);
    lowseen = 0;
    repeat (600) begin
      @(posedge clk); #1;
      if (!adc_cs_n) lowseen++;
    end
    check("idle_cs_low_cycles", 32'(lowseen), 32'd0);
    check("hold_ad1", 32'(ad1_out), 32'd450);
    check("hold_ad2", 32'(ad2_out), 32'd0);
    check("drop_no_valid", 32'(n_valid), 32'd5);

    // Fresh window after re-enable: 45 and 28665>>3 = 3583
    for (int j = 0; j < 8; j++) begin
      s1[j] = 12'(10 * (j + 1));
      s2[j] = (j < 7) ? 12'd4095 : 12'd0;
    end
    push_window(s1, s2, 12'd45, 12'd3583);
    ena = 1'b1;
    wait_cs_fall("reenable_cs_fall");
    tot = 0;
    while (!sample_valid && tot < 3000) begin
      tot++;
      @(posedge clk); #1;
    end
    check("reenable_latency", 32'(tot), 32'd1096);
    @(negedge clk); #1;
    check("reenable_valid_count", 32'(n_valid), 32'd6);

    // Mid-frame reset at bit 7 of frame 2; earlier frames carry 0xFFF
    def1 = 12'hFFF;
    def2 = 12'hFFF;
    wait_cs_fall("rst_frame1");
    wait_cs_fall("rst_frame2");
    repeat (57) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("async_rst_sclk", 32'(adc_sclk), 32'd1);
    check("async_rst_ad1", 32'(ad1_out), 32'd0);
    check("async_rst_ad2", 32'(ad2_out), 32'd0);
    check("async_rst_valid", 32'(sample_valid), 32'd0);
    repeat (3) @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      s1[j] = 12'h800;
      s2[j] = 12'(j + 1);
    end
    push_window(s1, s2, 12'h800, 12'd4);
    reset = 1'b1;
    @(posedge clk); #1;
    check("restart_cs_fall", 32'(adc_cs_n), 32'd0);
    wait_valids(7, 1500, "post_reset_window");
    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
